jtag_dl_rst_ctrl: RTL and testbench

- Parametrised core-reset controller for JTAG-to-AXI program download.
- Passively snoops the AXI write channels of the JTAG AXI master and holds the processor core in reset while a download is in progress.
- Adds the following: masked start/stop address match, drain of outstanding write responses before release, a minimum reset-hold time, an optional inactivity timeout, and download statistics/error status.
- Sits between the JTAG AXI master and the SoC interconnect. Observe-only: it never drives AXI.

---
 rtl/jtag_dl_rst_ctrl_pkg.sv | 29 ++
 rtl/jtag_dl_rst_ctrl_if.sv | 24 ++
 rtl/jtag_dl_rst_ctrl_sat_counter.sv | 40 ++++
 rtl/jtag_dl_rst_ctrl.sv | 161 ++++++++++++++++
 tb/tb_jtag_dl_rst_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_dl_rst_ctrl_pkg.sv
// Shared types, AXI response codes and width helper for the JTAG download
// core-reset controller.
package jtag_dl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DOWNLOAD = 2'd1,
    DRAIN    = 2'd2,
    HOLD     = 2'd3
  } dl_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Bits needed to hold values 0..value-1 (elaboration-time use only).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        width = i + 32'd1;
      end else begin
        width = width;
      end
    end
    return width;
  endfunction

endpackage

// File: rtl/jtag_dl_rst_ctrl_if.sv
// Snooped AXI write-channel bundle; master drives the observed wires, the
// controller only ever looks at them through the slave view.
interface jtag_dl_rst_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              s_awvalid;
  logic              s_awready;
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_wvalid;
  logic              s_wready;
  logic              s_bvalid;
  logic              s_bready;
  logic [1:0]        s_bresp;

  modport master (
    output s_awvalid, s_awready, s_awaddr, s_wvalid, s_wready,
           s_bvalid, s_bready, s_bresp
  );

  modport slave (
    input  s_awvalid, s_awready, s_awaddr, s_wvalid, s_wready,
           s_bvalid, s_bready, s_bresp
  );
endinterface

// File: rtl/jtag_dl_rst_ctrl_sat_counter.sv
// Saturating up/down counter with synchronous clear; clear applies before the
// same-cycle increment so a clearing event can also count itself.
module dl_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt
);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_MIN = {WIDTH{1'b0}};

  logic [WIDTH-1:0] cnt_q, cnt_d, base_s;

  // Next count: clear, then saturating step; inc with dec cancels out.
  always_comb begin
    base_s = clr ? CNT_MIN : cnt_q;
    cnt_d  = base_s;
    if (inc && !dec) begin
      if (base_s != CNT_MAX) cnt_d = base_s + WIDTH'(1'b1);
      else                   cnt_d = base_s;
    end else if (dec && !inc) begin
      if (base_s != CNT_MIN) cnt_d = base_s - WIDTH'(1'b1);
      else                   cnt_d = base_s;
    end else begin
      cnt_d = base_s;
    end
  end

  // Count register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cnt_q <= CNT_MIN;
    else          cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/jtag_dl_rst_ctrl.sv
// Core-reset controller: snoops JTAG AXI master writes and holds the core in
// reset from a start-address write until the download has drained and settled.
module jtag_dl_rst_ctrl
  import jtag_dl_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] START_ADDR  = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] STOP_ADDR   = 32'h4000_0000,
  parameter logic [ADDR_W-1:0] ADDR_MASK   = 32'hFFFF_FFFF,
  parameter int unsigned       HOLD_CYC    = 16,
  parameter int unsigned       TIMEOUT_CYC = 0,
  parameter int unsigned       OUT_W       = 6,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  jtag_dl_rst_ctrl_if.slave axi,
  output logic              core_rst_n,
  output logic              dl_active,
  output logic [CNT_W-1:0]  dl_beat_cnt,
  output logic              dl_err,
  output logic              timeout_evt
);
  localparam int unsigned HOLD_W = clog2((HOLD_CYC > 32'd1) ? HOLD_CYC : 32'd2);
  localparam int unsigned TMR_W  = clog2((TIMEOUT_CYC > 32'd1) ? TIMEOUT_CYC : 32'd2);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 32'd1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYC - 32'd1);
  localparam logic [OUT_W-1:0]  OUT_FULL  = {OUT_W{1'b1}};
  localparam logic [OUT_W-1:0]  OUT_EMPTY = {OUT_W{1'b0}};

  dl_state_e         state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              dl_active_q, dl_active_d;
  logic              dl_err_q, dl_err_d;
  logic              timeout_evt_q, timeout_evt_d;
  logic              aw_hs_s, w_hs_s, b_hs_s, start_s, stop_s;
  logic              new_dl_s, expire_s, beat_inc_s, err_set_s;
  logic [OUT_W-1:0]  out_cnt_s;

  assign aw_hs_s  = axi.s_awvalid & axi.s_awready;
  assign w_hs_s   = axi.s_wvalid & axi.s_wready;
  assign b_hs_s   = axi.s_bvalid & axi.s_bready;
  assign start_s  = aw_hs_s & ((axi.s_awaddr & ADDR_MASK) == (START_ADDR & ADDR_MASK));
  assign stop_s   = aw_hs_s & ((axi.s_awaddr & ADDR_MASK) == (STOP_ADDR & ADDR_MASK));
  // A start outside DOWNLOAD opens a fresh download (also restarts from DRAIN/HOLD).
  assign new_dl_s = start_s & (state_q != DOWNLOAD);
  assign expire_s = (TIMEOUT_CYC != 32'd0) & (state_q == DOWNLOAD) & ~aw_hs_s
                    & (tmr_q == TMR_LAST);
  assign beat_inc_s = w_hs_s & ((state_q != IDLE) | start_s);
  assign err_set_s  = (b_hs_s & ((axi.s_bresp & AXI_RESP_SLVERR) != 2'b00) & (state_q != IDLE))
                    | (aw_hs_s & (out_cnt_s == OUT_FULL));

  dl_sat_counter #(.WIDTH(OUT_W)) u_out_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (1'b0),
    .inc     (aw_hs_s),
    .dec     (b_hs_s),
    .cnt     (out_cnt_s)
  );

  dl_sat_counter #(.WIDTH(CNT_W)) u_beat_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (new_dl_s),
    .inc     (beat_inc_s),
    .dec     (1'b0),
    .cnt     (dl_beat_cnt)
  );

  // Next state, hold/idle timers and next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    timeout_evt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_s) state_d = DOWNLOAD;
        else         state_d = IDLE;
      end
      DOWNLOAD: begin
        if (stop_s) begin
          state_d = DRAIN;
        end else if (expire_s) begin
          state_d       = DRAIN;
          timeout_evt_d = 1'b1;
        end else begin
          state_d = DOWNLOAD;
        end
      end
      DRAIN: begin
        if (start_s) begin
          state_d = DOWNLOAD;
        end else if ((out_cnt_s == OUT_EMPTY) && !aw_hs_s) begin
          if (HOLD_CYC == 32'd0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            hold_d  = {HOLD_W{1'b0}};
          end
        end else begin
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (start_s) begin
          state_d = DOWNLOAD;
        end else if (hold_q == HOLD_LAST) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
          hold_d  = hold_q + HOLD_W'(1'b1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (new_dl_s) begin
      tmr_d = {TMR_W{1'b0}};
    end else if (state_q == DOWNLOAD) begin
      if (aw_hs_s) tmr_d = {TMR_W{1'b0}};
      else         tmr_d = tmr_q + TMR_W'(1'b1);
    end else begin
      tmr_d = tmr_q;
    end

    if (new_dl_s) dl_err_d = err_set_s;
    else          dl_err_d = dl_err_q | err_set_s;

    core_rst_n_d = (state_d == IDLE);
    dl_active_d  = (state_d != IDLE);
  end

  // State, timers and status registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      hold_q        <= {HOLD_W{1'b0}};
      tmr_q         <= {TMR_W{1'b0}};
      core_rst_n_q  <= 1'b0;
      dl_active_q   <= 1'b0;
      dl_err_q      <= 1'b0;
      timeout_evt_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      tmr_q         <= tmr_d;
      core_rst_n_q  <= core_rst_n_d;
      dl_active_q   <= dl_active_d;
      dl_err_q      <= dl_err_d;
      timeout_evt_q <= timeout_evt_d;
    end
  end

  assign core_rst_n  = core_rst_n_q;
  assign dl_active   = dl_active_q;
  assign dl_err      = dl_err_q;
  assign timeout_evt = timeout_evt_q;
endmodule

// File: tb/tb_jtag_dl_rst_ctrl.sv
// Bench for jtag_dl_rst_ctrl: directed download scenarios plus random traffic,
// every cycle compared against a phase-level reference model.
module tb_jtag_dl_rst_ctrl;
  import jtag_dl_pkg::*;

  localparam logic [31:0] START_A = 32'h8000_0000;
  localparam logic [31:0] STOP_A  = 32'h4000_0000;
  localparam logic [31:0] MASK_A  = 32'hFFFF_FFFF;
  localparam int HOLD     = 16;
  localparam int TMO      = 100;
  localparam int OUT_W    = 6;
  localparam int CNT_W    = 8;
  localparam int OUT_MAX  = (1 << OUT_W) - 1;
  localparam int BEAT_MAX = (1 << CNT_W) - 1;
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_DRAIN = 2, PH_HOLD = 3;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic             core_rst_n, dl_active, dl_err, timeout_evt;
  logic [CNT_W-1:0] dl_beat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: download phase plus plain integer bookkeeping.
  int   m_phase, m_out, m_beats, m_quiet, m_hold_left;
  logic m_err, m_rst_n, m_active, m_tevt;

  jtag_dl_rst_ctrl_if #(.ADDR_W(32)) axi ();

  jtag_dl_rst_ctrl #(
    .ADDR_W(32), .START_ADDR(START_A), .STOP_ADDR(STOP_A), .ADDR_MASK(MASK_A),
    .HOLD_CYC(HOLD), .TIMEOUT_CYC(TMO), .OUT_W(OUT_W), .CNT_W(CNT_W)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .axi(axi),
    .core_rst_n(core_rst_n), .dl_active(dl_active), .dl_beat_cnt(dl_beat_cnt),
    .dl_err(dl_err), .timeout_evt(timeout_evt)
  );

  always #5 aclk = ~aclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE; m_out = 0; m_beats = 0; m_quiet = 0; m_hold_left = 0;
    m_err = 1'b0; m_rst_n = 1'b0; m_active = 1'b0; m_tevt = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently on the bus.
  task automatic model_step();
    bit aw, w, b, st, sp, fresh, bad;
    int nxt;
    aw = axi.s_awvalid && axi.s_awready;
    w  = axi.s_wvalid && axi.s_wready;
    b  = axi.s_bvalid && axi.s_bready;
    st = aw && ((axi.s_awaddr & MASK_A) == (START_A & MASK_A));
    sp = aw && ((axi.s_awaddr & MASK_A) == (STOP_A & MASK_A));
    fresh  = st && (m_phase != PH_LOAD);
    m_tevt = (m_phase == PH_LOAD) && !aw && (TMO != 0) && (m_quiet + 1 == TMO);
    bad = (b && axi.s_bresp[1] && m_phase != PH_IDLE) || (aw && m_out == OUT_MAX);
    if (fresh) m_beats = 0;
    if (w && (m_phase != PH_IDLE || st) && m_beats < BEAT_MAX) m_beats++;
    m_err = fresh ? bad : (m_err | bad);
    nxt = m_phase;
    case (m_phase)
      PH_IDLE:  if (st) nxt = PH_LOAD;
      PH_LOAD:  if (sp || m_tevt) nxt = PH_DRAIN;
      PH_DRAIN: begin
        if (st) nxt = PH_LOAD;
        else if (m_out == 0 && !aw) begin
          nxt = (HOLD == 0) ? PH_IDLE : PH_HOLD;
          m_hold_left = HOLD;
        end
      end
      PH_HOLD: begin
        if (st) nxt = PH_LOAD;
        else if (m_hold_left == 1) nxt = PH_IDLE;
        else m_hold_left--;
      end
      default: nxt = PH_IDLE;
    endcase
    if (fresh) m_quiet = 0;
    else if (m_phase == PH_LOAD) m_quiet = aw ? 0 : m_quiet + 1;
    if (aw && !b && m_out < OUT_MAX) m_out++;
    else if (b && !aw && m_out > 0) m_out--;
    m_phase  = nxt;
    m_active = (nxt != PH_IDLE);
    m_rst_n  = (nxt == PH_IDLE);
  endtask

  task automatic compare_outputs();
    chk("core_rst_n", 32'(core_rst_n), 32'(m_rst_n));
    chk("dl_active", 32'(dl_active), 32'(m_active));
    chk("dl_beat_cnt", 32'(dl_beat_cnt), 32'(m_beats));
    chk("dl_err", 32'(dl_err), 32'(m_err));
    chk("timeout_evt", 32'(timeout_evt), 32'(m_tevt));
  endtask

  task automatic step();
    model_step();
    @(posedge aclk);
    #1;
    compare_outputs();
  endtask

  task automatic bus_idle();
    axi.s_awvalid = 1'b0; axi.s_awready = 1'b0; axi.s_awaddr = 32'h0;
    axi.s_wvalid = 1'b0; axi.s_wready = 1'b0;
    axi.s_bvalid = 1'b0; axi.s_bready = 1'b0; axi.s_bresp = AXI_RESP_OKAY;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if (a == START_A || a == STOP_A) a = 32'h1000_0000;
    return a;
  endfunction

  task automatic do_aw(input logic [31:0] addr, input logic with_w);
    repeat ($urandom_range(0, 2)) begin
      axi.s_awvalid = 1'b1; axi.s_awready = 1'b0; axi.s_awaddr = addr; step();
    end
    axi.s_awvalid = 1'b1; axi.s_awready = 1'b1; axi.s_awaddr = addr;
    axi.s_wvalid = with_w; axi.s_wready = with_w;
    step();
    bus_idle();
  endtask

  task automatic do_w();
    repeat ($urandom_range(0, 1)) begin
      axi.s_wvalid = 1'b1; axi.s_wready = 1'b0; step();
    end
    axi.s_wvalid = 1'b1; axi.s_wready = 1'b1; step();
    bus_idle();
  endtask

  task automatic do_b(input logic [1:0] resp);
    repeat ($urandom_range(0, 2)) begin
      axi.s_bvalid = 1'b1; axi.s_bready = 1'b0; axi.s_bresp = resp; step();
    end
    axi.s_bvalid = 1'b1; axi.s_bready = 1'b1; axi.s_bresp = resp; step();
    bus_idle();
  endtask

  // Idle until the core leaves reset; n is the number of cycles taken.
  task automatic wait_release(output int n);
    n = 0;
    while (core_rst_n !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int r;
    bus_idle();
    model_reset();
    repeat (5) @(posedge aclk);
    #1;
    compare_outputs();
    aresetn = 1'b1;
    step();
    chk("release_core_rst", 32'(core_rst_n), 32'd1);

    // Plain writes outside the start address leave the core running.
    do_aw(32'h1000_0000, 1'b1);
    chk("plain_core_rst", 32'(core_rst_n), 32'd1);
    do_b(AXI_RESP_OKAY);
    chk("plain_active", 32'(dl_active), 32'd0);

    // Basic download: start with data, 7 more writes, 8 responses, stop.
    do_aw(START_A, 1'b1);
    chk("basic_start_rst", 32'(core_rst_n), 32'd0);
    repeat (7) do_aw(rand_addr(), 1'b1);
    repeat (8) do_b(AXI_RESP_OKAY);
    do_aw(STOP_A, 1'b1);
    chk("basic_drain_rst", 32'(core_rst_n), 32'd0);
    do_b(AXI_RESP_OKAY);
    wait_release(n);
    chk("basic_hold_len", 32'(n), 32'(HOLD + 1));
    chk("basic_beats", 32'(dl_beat_cnt), 32'd9);

    // Stop with three responses still outstanding.
    do_aw(START_A, 1'b1);
    do_aw(rand_addr(), 1'b1);
    do_aw(STOP_A, 1'b1);
    repeat ($urandom_range(3, 8)) step();
    chk("drain_wait_rst", 32'(core_rst_n), 32'd0);
    do_b(AXI_RESP_OKAY);
    do_b(AXI_RESP_OKAY);
    chk("drain_two_b_rst", 32'(core_rst_n), 32'd0);
    do_b(AXI_RESP_OKAY);
    wait_release(n);
    chk("drain_hold_len", 32'(n), 32'(HOLD + 1));

    // Error response is sticky across release and cleared by the next start.
    do_aw(START_A, 1'b1);
    do_b(AXI_RESP_SLVERR);
    chk("err_set", 32'(dl_err), 32'd1);
    do_aw(STOP_A, 1'b0);
    do_b(AXI_RESP_OKAY);
    wait_release(n);
    chk("err_sticky", 32'(dl_err), 32'd1);
    do_aw(START_A, 1'b0);
    chk("err_clear", 32'(dl_err), 32'd0);
    do_b(AXI_RESP_OKAY);
    do_aw(STOP_A, 1'b0);
    do_b(AXI_RESP_OKAY);
    wait_release(n);

    // Inactivity timeout.
    do_aw(START_A, 1'b1);
    n = 0;
    while (timeout_evt !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("tmo_len", 32'(n), 32'(TMO));
    chk("tmo_core_rst", 32'(core_rst_n), 32'd0);
    step();
    chk("tmo_pulse_end", 32'(timeout_evt), 32'd0);
    do_b(AXI_RESP_OKAY);
    wait_release(n);
    chk("tmo_hold_len", 32'(n), 32'(HOLD + 1));

    // Restart while holding.
    do_aw(START_A, 1'b1);
    do_b(AXI_RESP_OKAY);
    do_aw(STOP_A, 1'b0);
    do_b(AXI_RESP_OKAY);
    repeat (5) begin
      step();
      chk("hold_core_rst", 32'(core_rst_n), 32'd0);
    end
    do_aw(START_A, 1'b1);
    chk("restart_core_rst", 32'(core_rst_n), 32'd0);
    chk("restart_beats", 32'(dl_beat_cnt), 32'd1);
    do_b(AXI_RESP_OKAY);
    do_aw(STOP_A, 1'b0);
    do_b(AXI_RESP_OKAY);
    wait_release(n);
    chk("restart_hold_len", 32'(n), 32'(HOLD + 1));

    // Asynchronous reset in the middle of a download.
    do_aw(START_A, 1'b1);
    repeat (3) do_w();
    aresetn = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    chk("arst_beats", 32'(dl_beat_cnt), 32'd0);
    repeat (2) begin
      @(posedge aclk);
      #1;
      compare_outputs();
    end
    aresetn = 1'b1;
    step();
    chk("arst_release_rst", 32'(core_rst_n), 32'd1);

    // Outstanding and beat counter saturation.
    do_aw(START_A, 1'b1);
    repeat (OUT_MAX) do_aw(rand_addr(), 1'b0);
    chk("out_sat_err", 32'(dl_err), 32'd1);
    repeat (BEAT_MAX + 5) do_w();
    chk("beat_sat", 32'(dl_beat_cnt), 32'(BEAT_MAX));
    do_aw(STOP_A, 1'b0);
    repeat (OUT_MAX) do_b(AXI_RESP_OKAY);
    wait_release(n);
    chk("sat_hold_len", 32'(n), 32'(HOLD + 1));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 15));
      axi.s_awvalid = ($urandom_range(0, 3) == 0);
      axi.s_awready = ($urandom_range(0, 3) != 0);
      axi.s_awaddr  = (r < 2) ? START_A : ((r < 4) ? STOP_A : rand_addr());
      axi.s_wvalid  = ($urandom_range(0, 1) == 0);
      axi.s_wready  = ($urandom_range(0, 3) != 0);
      axi.s_bvalid  = ($urandom_range(0, 3) == 0);
      axi.s_bready  = ($urandom_range(0, 3) != 0);
      axi.s_bresp   = ($urandom_range(0, 15) == 0) ? AXI_RESP_SLVERR : 2'($urandom_range(0, 1));
      step();
    end
    bus_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
